// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - IFU fetch sequencer and halfword aligner
// Purpose: issues word-aligned fetches, buffers returned words as halfwords and
//          presents a 32-bit instruction window with its PC to the decompressor.
// Ports:   clk, rst_n (async active-low)
//          redirect_i/redirect_pc_i        : flush and restart fetch
//          req_valid_o/req_ready_i/req_addr_o : fetch request channel
//          resp_valid_i/resp_data_i        : fetched word, one per accepted request
//          instr_valid_o/instr_ready_i/instr_o/instr_pc_o/instr_compressed_o
//          perf_starve_o (only with FETCH_ALIGN_PERF_EN): saturating starve-cycle count
// Macro:   FETCH_ALIGN_PERF_EN enables the starvation performance counter.
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o
`ifdef FETCH_ALIGN_PERF_EN
    ,
    output logic [31:0] perf_starve_o
`endif
);

    localparam int PW = $clog2(BUF_HW);
    localparam int CW = $clog2(BUF_HW + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_HW - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DISCARD
    } state_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic          drop_q, drop_d;
    logic          fetch_en_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   hw_mem [BUF_HW];

    logic [PW-1:0] rd_ptr_p1, wr_ptr_p1;
    logic [15:0]   hw0, hw1;
    logic          needs2, have1, have2, fire, accept;
    logic [1:0]    pop_n;
    logic [4:0]    room_need;
    logic          clear, push_en;

    assign rd_ptr_p1 = ptr_inc(rd_ptr_q);
    assign wr_ptr_p1 = ptr_inc(wr_ptr_q);
    assign hw0       = hw_mem[rd_ptr_q];
    assign hw1       = hw_mem[rd_ptr_p1];

    assign needs2 = (hw0[1:0] == 2'b11);
    assign have1  = (count_q != '0);
    assign have2  = (count_q >= CW'(2));

    assign instr_valid_o      = needs2 ? have2 : have1;
    assign instr_o            = {have2 ? hw1 : 16'h0, hw0};
    assign instr_pc_o         = out_pc_q;
    assign instr_compressed_o = ~needs2;

    assign fire  = instr_valid_o & instr_ready_i;
    assign pop_n = fire ? (needs2 ? 2'd2 : 2'd1) : 2'd0;

    // Space check uses the post-pop count so a word can be requested while the
    // consumer drains. In RUN nothing is pushed, so once true it stays true
    // and the request holds stable until accepted.
    assign room_need   = 5'(count_q) - 5'(pop_n) + 5'd2;
    assign req_valid_o = fetch_en_q && (state_q == S_RUN) && (room_need <= 5'(BUF_HW));
    assign req_addr_o  = fetch_pc_q;
    assign accept      = req_valid_o & req_ready_i;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_pc_d   = out_pc_q;
        drop_d     = drop_q;
        clear      = 1'b0;
        push_en    = 1'b0;
        if (redirect_i) begin
            clear      = 1'b1;
            fetch_pc_d = redirect_pc_i & ~32'h3;
            out_pc_d   = redirect_pc_i & ~32'h1;
            drop_d     = redirect_pc_i[1];
            case (state_q)
                S_RUN:             state_d = accept ? S_DISCARD : S_RUN;
                // A response landing in the redirect cycle is the outstanding one.
                S_WAIT, S_DISCARD: state_d = resp_valid_i ? S_RUN : S_DISCARD;
                default:           state_d = S_RUN;
            endcase
        end else begin
            if (fire) begin
                out_pc_d = out_pc_q + (needs2 ? 32'd4 : 32'd2);
            end
            case (state_q)
                S_RUN: begin
                    if (accept) begin
                        state_d    = S_WAIT;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (resp_valid_i) begin
                        push_en = 1'b1;
                        drop_d  = 1'b0;
                        state_d = S_RUN;
                    end
                end
                S_DISCARD: begin
                    if (resp_valid_i) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // Halfword FIFO pointers; a drop_first response contributes only [31:16].
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (pop_n)
                2'd1:    rd_ptr_d = rd_ptr_p1;
                2'd2:    rd_ptr_d = ptr_inc(rd_ptr_p1);
                default: rd_ptr_d = rd_ptr_q;
            endcase
            if (push_en) begin
                wr_ptr_d = drop_q ? wr_ptr_p1 : ptr_inc(wr_ptr_p1);
            end
            count_d = count_q - CW'(pop_n)
                    + (push_en ? (drop_q ? CW'(1) : CW'(2)) : CW'(0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC & ~32'h3;
            out_pc_q   <= RESET_PC & ~32'h1;
            drop_q     <= RESET_PC[1];
            fetch_en_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < BUF_HW; i++) begin
                hw_mem[i] <= 16'h0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_pc_q   <= out_pc_d;
            drop_q     <= drop_d;
            fetch_en_q <= 1'b1;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (push_en) begin
                if (drop_q) begin
                    hw_mem[wr_ptr_q] <= resp_data_i[31:16];
                end else begin
                    hw_mem[wr_ptr_q]  <= resp_data_i[15:0];
                    hw_mem[wr_ptr_p1] <= resp_data_i[31:16];
                end
            end
        end
    end

`ifdef FETCH_ALIGN_PERF_EN
    logic [31:0] starve_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 32'h0;
        end else if (!instr_valid_o && !redirect_i && (state_q != S_DISCARD)
                     && (starve_q != 32'hFFFF_FFFF)) begin
            starve_q <= starve_q + 32'd1;
        end
    end
    assign perf_starve_o = starve_q;
`endif

`ifndef SYNTHESIS
    // A response for a request issued before reset may still land after
    // release; tolerate it until this block accepts its own first request.
    logic boot_grace_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_grace_q <= 1'b1;
        end else if (accept) begin
            boot_grace_q <= 1'b0;
        end
    end

    resp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_valid_i && (state_q == S_RUN) && !boot_grace_q));
`endif

endmodule

// File: tb/tb_fetch_align.sv
// tb/tb_fetch_align.sv - randomized scoreboard bench for fetch_align
module tb_fetch_align;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          BUF_HW   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [31:0] req_addr_o;
    logic        resp_valid_i = 1'b0;
    logic [31:0] resp_data_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_compressed_o;

    always #5 clk = ~clk;

    fetch_align #(.RESET_PC(RESET_PC), .BUF_HW(BUF_HW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .redirect_i         (redirect_i),
        .redirect_pc_i      (redirect_pc_i),
        .req_valid_o        (req_valid_o),
        .req_ready_i        (req_ready_i),
        .req_addr_o         (req_addr_o),
        .resp_valid_i       (resp_valid_i),
        .resp_data_i        (resp_data_i),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        c;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] model_pc, stream_start, delivered_end;
    bit          pending = 0;
    logic [31:0] paddr;
    int          pgen, gen = 0, cd = 0;
    int          ird_pct = 100, rrq_pct = 100, lat_min = 1, lat_max = 1;
    int          accepts = 0, consumed = 0;
    bit          cur_redir = 0, last_redir = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = 32'h0;
    bit          want_addr_chk = 0;
    logic [31:0] want_addr = 32'h0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [15:0] h [2];
        for (int k = 0; k < 2; k++) begin
            h[k] = 16'($urandom);
            if ($urandom_range(1) == 1) h[k][1:0] = 2'b11;
            else if (h[k][1:0] == 2'b11) h[k][1:0] = 2'b01;
        end
        return {h[1], h[0]};
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem[pc[9:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference instruction stream: walk memory from model_pc by the length rule.
    task automatic fill();
        logic [15:0] h;
        exp_t        e;
        while (exp_q.size() < 16) begin
            h    = hw_at(model_pc);
            e.pc = model_pc;
            if (h[1:0] == 2'b11) begin
                e.ins = {hw_at(model_pc + 32'd2), h};
                e.c   = 1'b0;
                model_pc += 32'd4;
            end else begin
                e.ins = {16'h0, h};
                e.c   = 1'b1;
                model_pc += 32'd2;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        gen++;
        stream_start  = pc & ~32'h1;
        delivered_end = stream_start;
        model_pc      = stream_start;
        exp_q.delete();
        fill();
    endtask

    // One clock of stimulus plus memory model and request-channel checks.
    task automatic step(input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        last_redir    = cur_redir;
        cur_redir     = redir;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        instr_ready_i = !redir && ($urandom_range(99) < ird_pct);
        req_ready_i   = ($urandom_range(99) < rrq_pct);
        resp_valid_i  = 1'b0;
        resp_data_i   = $urandom;
        if (pending) begin
            if (cd == 0) begin
                resp_valid_i = 1'b1;
                resp_data_i  = mem[paddr[9:2]];
                if (pgen == gen && !redir) delivered_end = paddr + 32'd4;
                pending = 0;
            end else begin
                cd--;
            end
        end
        if (redir) restart(rpc);
        #1;
        if (rst_n) begin
            if (prev_stall && !last_redir)
                chk(req_valid_o && req_addr_o == prev_addr, "req_hold", req_addr_o, prev_addr);
            if (req_valid_o && req_ready_i) begin
                chk(!pending, "one_outstanding", {31'h0, pending}, 32'h0);
                chk(req_addr_o[1:0] == 2'b00, "req_align", req_addr_o, req_addr_o & ~32'h3);
                if (want_addr_chk) begin
                    chk(req_addr_o == want_addr, "first_req_addr", req_addr_o, want_addr);
                    want_addr_chk = 0;
                end
                pending = 1;
                paddr   = req_addr_o;
                pgen    = redir ? gen - 1 : gen;
                cd      = int'($urandom_range(lat_max, lat_min)) - 1;
                accepts++;
            end
            prev_stall = req_valid_o && !req_ready_i;
            prev_addr  = req_addr_o;
        end
    endtask

    // Monitor: pops the scoreboard whenever the consumer takes an instruction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (last_redir)
                    chk(!instr_valid_o, "flush_valid", {31'h0, instr_valid_o}, 32'h0);
                if (instr_valid_o && instr_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "exp_empty", instr_pc_o, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(instr_pc_o == e.pc, "instr_pc", instr_pc_o, e.pc);
                        chk(instr_compressed_o == e.c, "compressed", {31'h0, instr_compressed_o}, {31'h0, e.c});
                        chk((e.c ? {16'h0, instr_o[15:0]} : instr_o) == e.ins, "instr", instr_o, e.ins);
                        chk((instr_pc_o - stream_start) + (e.c ? 32'd2 : 32'd4) <= delivered_end - stream_start,
                            "early_valid", instr_pc_o, delivered_end);
                        consumed++;
                        fill();
                    end
                end
            end
        end
    end

    initial begin : main
        int c0, a0, n;
        logic [31:0] rpc;
        for (int i = 0; i < 256; i++) mem[i] = rand_word();

        // Basic compressed/uncompressed sequence out of reset.
        mem[0] = 32'h0001_0001;
        mem[1] = 32'h0000_0013;
        restart(RESET_PC);
        #12;
        chk(!req_valid_o, "rst_req_valid", {31'h0, req_valid_o}, 32'h0);
        chk(!instr_valid_o, "rst_instr_valid", {31'h0, instr_valid_o}, 32'h0);
        chk(instr_pc_o == RESET_PC, "rst_pc", instr_pc_o, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step(1'b0, 32'h0);
        chk(consumed >= 3, "t0_progress", consumed, 3);

        // Straddling 32-bit instruction with a slow second word.
        mem[0] = 32'h0093_0001;
        mem[1] = 32'h1111_0000;
        lat_min = 3; lat_max = 3;
        c0 = consumed;
        step(1'b1, 32'h0);
        repeat (30) step(1'b0, 32'h0);
        chk(consumed - c0 >= 2, "t1_progress", consumed - c0, 2);

        // Redirect while a response is outstanding.
        lat_min = 4; lat_max = 4;
        step(1'b1, 32'h0);
        n = 0;
        while (!(pending && pgen == gen) && n < 20) begin
            step(1'b0, 32'h0);
            n++;
        end
        chk(pending, "t2_wait", {31'h0, pending}, 32'h1);
        want_addr = 32'h100;
        want_addr_chk = 1;
        step(1'b1, 32'h0000_0102);
        repeat (30) step(1'b0, 32'h0);
        chk(!want_addr_chk, "t2_refetch", {31'h0, want_addr_chk}, 32'h0);

        // Consumer stalled: buffer fills with exactly two words, then drains.
        lat_min = 1; lat_max = 1;
        ird_pct = 0;
        step(1'b1, 32'h200);
        a0 = accepts;
        repeat (30) step(1'b0, 32'h0);
        chk(accepts - a0 == 2, "t3_words", accepts - a0, 2);
        chk(!req_valid_o, "t3_req_idle", {31'h0, req_valid_o}, 32'h0);
        ird_pct = 100;
        c0 = consumed;
        repeat (30) step(1'b0, 32'h0);
        chk(consumed - c0 >= 4, "t3_drain", consumed - c0, 4);

        // Memory not ready: address holds, one acceptance.
        rrq_pct = 0;
        step(1'b1, 32'h300);
        repeat (2) step(1'b0, 32'h0);
        repeat (5) begin
            step(1'b0, 32'h0);
            chk(req_valid_o && req_addr_o == 32'h300, "t4_hold", req_addr_o, 32'h300);
        end
        a0 = accepts;
        rrq_pct = 100;
        step(1'b0, 32'h0);
        rrq_pct = 0;
        repeat (3) step(1'b0, 32'h0);
        chk(accepts - a0 == 1, "t4_one_accept", accepts - a0, 1);
        rrq_pct = 100;
        repeat (10) step(1'b0, 32'h0);

        // Asynchronous reset during WAIT, stale response afterwards.
        lat_min = 6; lat_max = 6;
        step(1'b1, 32'h40);
        n = 0;
        while (!(pending && pgen == gen) && n < 20) begin
            step(1'b0, 32'h0);
            n++;
        end
        chk(pending, "t5_wait", {31'h0, pending}, 32'h1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        cd = 3;
        restart(RESET_PC);
        prev_stall = 0;
        last_redir = 0;
        cur_redir = 0;
        #1;
        chk(!req_valid_o, "t5_rst_req", {31'h0, req_valid_o}, 32'h0);
        chk(!instr_valid_o, "t5_rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk(instr_pc_o == RESET_PC, "t5_rst_pc", instr_pc_o, RESET_PC);
        rrq_pct = 0;
        repeat (2) step(1'b0, 32'h0);
        rst_n = 1'b1;
        n = 0;
        while (pending && n < 10) begin
            step(1'b0, 32'h0);
            n++;
        end
        chk(!pending, "t5_stale_sent", {31'h0, pending}, 32'h0);
        rrq_pct = 100;
        lat_min = 1; lat_max = 2;
        c0 = consumed;
        repeat (30) step(1'b0, 32'h0);
        chk(consumed - c0 >= 4, "t5_progress", consumed - c0, 4);

        // Randomized traffic with redirects, odd targets and address wrap.
        ird_pct = 70; rrq_pct = 70; lat_min = 1; lat_max = 3;
        c0 = consumed;
        repeat (3000) begin
            if ($urandom_range(39) == 0) begin
                case ($urandom_range(2))
                    0:       rpc = $urandom;
                    1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                    default: rpc = $urandom & 32'h0000_03FE;
                endcase
                step(1'b1, rpc);
            end else begin
                step(1'b0, 32'h0);
            end
        end
        chk(consumed - c0 > 200, "t6_progress", consumed - c0, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- Fetch sequencer and halfword aligner for the IFU.
- Issues word-aligned fetch requests to instruction memory and buffers returned words as halfwords.
- Presents a 32-bit instruction window, with its PC, to the decompressor, handling 16-bit instructions and 32-bit instructions that straddle words.
- Handles control-flow redirects, including discarding an in-flight stale response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bit 0 ignored).
- BUF_HW, 4, halfword buffer depth; legal values 4..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_i  in  1  flush pipeline and restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  new PC; bit 0 ignored.
- req_valid_o  out  1  fetch request valid.
- req_ready_i  in  1  memory accepts request.
- req_addr_o  out  32  word-aligned fetch address; [1:0]=0.
- resp_valid_i  in  1  fetch data returned; one cycle per accepted request.
- resp_data_i  in  32  fetched word; halfword 0 is [15:0].
- instr_valid_o  out  1  instr_o/instr_pc_o valid.
- instr_ready_i  in  1  consumer takes instruction.
- instr_o  out  32  window for decompressor; [15:0] is the instruction's first halfword.
- instr_pc_o  out  32  PC of instr_o; bit 0 = 0.
- instr_compressed_o  out  1  instr_o[1:0] != 2'b11.

Behaviour:
- Reset values:
  - req_valid_o=0, instr_valid_o=0, buffer count=0.
  - fetch_pc=RESET_PC&~3, drop_first=RESET_PC[1].
  - State RUN, and the buffer-driven outputs/PC defined below.
- Buffer: FIFO of BUF_HW halfwords; out_pc tracks the head halfword.
- Instruction size: head[1:0]==2'b11 needs 2 halfwords, else 1.
- instr_valid_o=1 when count ≥ needed size; combinational from buffer state.
- instr_o = {hw1, hw0}. When only 1 halfword is valid and the instruction is compressed, [31:16] is driven 16'h0.
- Consume on instr_valid_o && instr_ready_i: pop 1 or 2 halfwords; out_pc += 2 or 4.
- Request rule: req_valid_o=1 in RUN when (count − pop_this_cycle + 2) ≤ BUF_HW. Max one outstanding request.
- Request acceptance (req_valid_o && req_ready_i):
  - Go to WAIT.
  - fetch_pc += 4.
  - req_valid_o and req_addr_o must hold stable while waiting for ready.
- Response handling:
  - In WAIT with resp_valid_i: push 2 halfwords; return to RUN.
  - If drop_first=1, push only [31:16] and clear drop_first.
  - Push and pop in the same cycle are legal; count updates by net amount.
- States:
  - RUN: no request outstanding.
  - WAIT: request accepted, response pending.
  - DISCARD: stale response pending.
- Redirect (highest priority, any state):
  - Clear buffer; instr_valid_o=0 next cycle.
  - fetch_pc=redirect_pc_i&~3, out_pc=redirect_pc_i&~1, drop_first=redirect_pc_i[1].
  - From WAIT go to DISCARD. From RUN (including a request being accepted this cycle) go to DISCARD if accepted, else RUN.
  - A resp_valid_i in the redirect cycle itself is dropped and counts as the outstanding response; if it arrives, go to RUN, not DISCARD.
- DISCARD: no requests issued. On resp_valid_i, drop the data and go to RUN.
- Redirect while in DISCARD: stay in DISCARD and update PCs.
- resp_valid_i in RUN: protocol error; ignored. Assertion fires in simulation.
- PC arithmetic is modulo 2^32; fetch_pc wraps 32'hFFFF_FFFC → 0.
- Asynchronous reset mid-operation: return to reset values immediately. Any in-flight response after reset release arrives in RUN and is ignored.

Optional Feature:
- Macro FETCH_ALIGN_PERF_EN.
- When defined: adds output perf_starve_o (32 bits).
  - Counts cycles with instr_valid_o=0 and redirect_i=0 and state≠DISCARD.
  - Reset 0; saturates at 32'hFFFF_FFFF.
- When undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset with RESET_PC=0; memory always ready, 1-cycle response; words 32'h0001_0001 then 32'h0000_0013 → compressed 16'h0001 at pc 0, 16'h0001 at pc 2, then instr_o=32'h0000_0013 uncompressed at pc 4.
- Straddle: words 32'h0093_0001, 32'h1111_0000 → 16'h0001 at pc 0, then instr_o=32'h0000_0093 at pc 2, instr_compressed_o=0; it is not valid until the second word is pushed.
- Redirect to 32'h0000_0102 while WAIT → next req_addr_o=32'h100 only after the stale response is dropped; first instr_pc_o=32'h102 sourced from [31:16].
- instr_ready_i held 0 with BUF_HW=4 → at most 2 words fetched; req_valid_o=0 while count=4; data not lost when ready is released.
- req_ready_i low for 5 cycles → req_addr_o stable throughout; exactly one request is accepted.
- rst_n asserted mid-WAIT, released, stale resp_valid_i pulse → ignored; first instruction is from RESET_PC.
